wb_arbiter2: RTL and testbench

//   Shares one pipelined Wishbone master port between two masters (instr m0, data m1).

---
 rtl/wb_arbiter2.sv | 107 ++++++++++
 tb/tb_wb_arbiter2.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master pipelined Wishbone arbiter with outstanding tracking and timeout abort
module wb_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic [AW-1:0]   m0_adr,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack,
  output logic            m0_err,
  output logic            m0_stall,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic [AW-1:0]   m1_adr,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack,
  output logic            m1_err,
  output logic            m1_stall,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic            s_stall
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic own, own_n, last, last_n;
  logic [CW-1:0] out_cnt, out_n;
  logic [TW-1:0] timer, timer_n;
  logic busy, o_cyc, o_stb, full, tmo, resp, acc;
  assign busy = state == BUSY;
  assign o_cyc = own ? m1_cyc : m0_cyc;
  assign o_stb = own ? m1_stb : m0_stb;
  assign full = out_cnt == CW'(MAX_OUT);
  assign tmo = busy & (timer == TW'(TIMEOUT));
  assign resp = s_ack | s_err;
  assign acc = s_stb & ~s_stall;
  assign s_cyc = busy & o_cyc & ~tmo;
  assign s_stb = busy & o_stb & ~full & ~tmo;
  assign s_we = own ? m1_we : m0_we;
  assign s_adr = own ? m1_adr : m0_adr;
  assign s_sel = own ? m1_sel : m0_sel;
  assign s_dat_o = own ? m1_dat_i : m0_dat_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack = busy & ~own & s_ack & ~tmo;
  assign m1_ack = busy & own & s_ack & ~tmo;
  assign m0_err = busy & ~own & (s_err | tmo);
  assign m1_err = busy & own & (s_err | tmo);
  assign m0_stall = ~busy | own | s_stall | full;
  assign m1_stall = ~busy | ~own | s_stall | full;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      own <= 1'b0;
      last <= 1'b1;
      out_cnt <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      own <= own_n;
      last <= last_n;
      out_cnt <= out_n;
      timer <= timer_n;
    end
  end
  always_comb begin
    state_n = state;
    own_n = own;
    last_n = last;
    out_n = out_cnt;
    timer_n = timer;
    if (!busy) begin
      if (m0_cyc | m1_cyc) begin
        state_n = BUSY;
        own_n = (m0_cyc & m1_cyc) ? ~last : m1_cyc;
      end
    end else if (~o_cyc | tmo) begin
      state_n = IDLE;
      last_n = own;
      out_n = '0;
      timer_n = '0;
    end else begin
      // simultaneous accept and response cancel; a response with nothing outstanding is dropped
      out_n = (acc & ~resp) ? out_cnt + 1'b1 : (resp & ~acc & out_cnt != '0) ? out_cnt - 1'b1 : out_cnt;
      timer_n = (resp | out_cnt == '0) ? '0 : timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed stimulus with a queue-based reference model checked every cycle
module tb_wb_arbiter2;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 8;
  logic clk = 0, rst = 1;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  int vectors = 0, miscompares = 0;
  wb_arbiter2 #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
  );
  always #5 clk = ~clk;
  // reference model: ownership flags plus a queue of accepted, unanswered addresses
  logic m_busy = 0, m_own = 0, m_last = 1;
  int silent = 0, acc_total = 0;
  logic [31:0] q[$];
  logic o_cyc, o_stb, e_full, e_to, e_scyc, e_sstb;
  logic [1:0] e_ack, e_err, e_stall;
  function automatic void calc();
    o_cyc = m_own ? m1_cyc : m0_cyc;
    o_stb = m_own ? m1_stb : m0_stb;
    e_full = q.size() >= MAX_OUT;
    e_to = m_busy && silent == TIMEOUT;
    e_scyc = m_busy && o_cyc && !e_to;
    e_sstb = m_busy && o_stb && !e_full && !e_to;
    e_ack = 2'b00;
    e_err = 2'b00;
    e_stall = 2'b11;
    if (m_busy) begin
      e_ack[m_own] = s_ack && !e_to;
      e_err[m_own] = s_err || e_to;
      e_stall[m_own] = s_stall || e_full;
    end
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_last = 1;
      silent = 0;
      acc_total = 0;
      q.delete();
    end else begin
      calc();
      if (!m_busy) begin
        if (m0_cyc || m1_cyc) begin
          m_busy = 1;
          m_own = (m0_cyc && m1_cyc) ? !m_last : m1_cyc;
        end
      end else if (!o_cyc || e_to) begin
        m_busy = 0;
        m_last = m_own;
        silent = 0;
        q.delete();
      end else begin
        silent = (s_ack || s_err || q.size() == 0) ? 0 : silent + 1;
        if (e_sstb && !s_stall) begin
          q.push_back(m_own ? m1_adr : m0_adr);
          acc_total++;
        end
        if ((s_ack || s_err) && q.size() > 0) void'(q.pop_front());
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    calc();
    chk("s_cyc", s_cyc, e_scyc);
    chk("s_stb", s_stb, e_sstb);
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_stall", m0_stall, e_stall[0]);
    chk("m1_stall", m1_stall, e_stall[1]);
    chk("m0_dat_o", m0_dat_o, s_dat_i);
    chk("m1_dat_o", m1_dat_o, s_dat_i);
    if (e_scyc) begin
      chk("s_adr", s_adr, m_own ? m1_adr : m0_adr);
      chk("s_we", s_we, m_own ? m1_we : m0_we);
      chk("s_sel", s_sel, m_own ? m1_sel : m0_sel);
      chk("s_dat_o", s_dat_o, m_own ? m1_dat_i : m0_dat_i);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic clr();
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall} = '0;
    m0_adr = 32'h0000_0200; m1_adr = 32'h0000_0300;
    m0_we = 0; m1_we = 1; m0_sel = 4'hf; m1_sel = 4'h3;
    m0_dat_i = 32'h1111_0000; m1_dat_i = 32'h2222_0000; s_dat_i = 32'h0;
  endtask
  task automatic rst_pulse();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    clr();
    step();
    rst_pulse();
    #1;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_m0_ack", m0_ack, 0);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    #1 chk("t1_idle_stb", s_stb, 0);
    step();
    #1 chk("t1_s_stb", s_stb, 1);
    chk("t1_s_adr", s_adr, 32'h100);
    step();
    m0_stb = 0; s_ack = 1; s_dat_i = 32'hDEADBEEF;
    #1 chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_ack, 0);
    step();
    s_ack = 0; m0_cyc = 0;
    step();
    clr(); rst_pulse();
    m0_cyc = 1; m1_cyc = 1;
    step();
    #1 chk("t2_m0_grant", m0_stall, 0);
    chk("t2_m1_stall", m1_stall, 1);
    m0_cyc = 0;
    step();
    #1 chk("t2_idle_m1_stall", m1_stall, 1);
    step();
    #1 chk("t2_m1_grant", m1_stall, 0);
    chk("t2_m0_blocked", m0_stall, 1);
    m1_cyc = 0;
    step();
    m0_cyc = 1; m1_cyc = 1;
    step();
    #1 chk("t2_tie_m0", m0_stall, 0);
    m0_cyc = 0;
    step();
    m0_cyc = 1;
    step();
    #1 chk("t2_rr_m1", m1_stall, 0);
    chk("t2_rr_m0_stall", m0_stall, 1);
    clr(); rst_pulse();
    m0_cyc = 1; m0_stb = 1;
    step();
    repeat (4) step();
    #1 chk("t3_full_stb", s_stb, 0);
    chk("t3_full_stall", m0_stall, 1);
    step();
    #1 chk("t3_hold_stb", s_stb, 0);
    s_ack = 1;
    #1 chk("t3_ack_cycle_stb", s_stb, 0);
    step();
    s_ack = 0;
    #1 chk("t3_reopen_stb", s_stb, 1);
    step();
    s_ack = 1;
    step();
    s_ack = 0;
    step();
    m0_stb = 0; s_ack = 1;
    repeat (4) step();
    s_ack = 0;
    #1 chk("t3_accepted", acc_total, 6);
    chk("t3_model_empty", q.size(), 0);
    chk("t3_stall_clear", m0_stall, 0);
    m0_cyc = 0;
    step();
    clr(); rst_pulse();
    m1_cyc = 1; m1_stb = 1;
    step();
    step();
    m1_stb = 0;
    repeat (7) step();
    #1 chk("t4_pre_err", m1_err, 0);
    step();
    #1 chk("t4_err", m1_err, 1);
    chk("t4_s_cyc", s_cyc, 0);
    chk("t4_s_stb", s_stb, 0);
    chk("t4_m0_err", m0_err, 0);
    step();
    s_ack = 1;
    #1 chk("t4_err_once", m1_err, 0);
    chk("t4_late_ack", m1_ack, 0);
    chk("t4_idle_stall", m1_stall, 1);
    step();
    s_ack = 0; m1_cyc = 0;
    step();
    clr(); rst_pulse();
    m0_cyc = 1; m0_stb = 1;
    step();
    step();
    s_ack = 1;
    #1 chk("t5_both_stb", s_stb, 1);
    step();
    s_ack = 0;
    repeat (3) step();
    #1 chk("t5_full", s_stb, 0);
    chk("t5_model_cnt", q.size(), 4);
    m0_stb = 0; m0_cyc = 0;
    step();
    s_ack = 1;
    #1 chk("t5_idle_m0_ack", m0_ack, 0);
    chk("t5_idle_m1_ack", m1_ack, 0);
    step();
    clr(); rst_pulse();
    m0_cyc = 1; m0_stb = 1;
    step();
    repeat (3) step();
    m0_stb = 0;
    #1 chk("t6_model_cnt", q.size(), 3);
    s_ack = 1; rst = 1;
    #1 chk("t6_s_cyc", s_cyc, 0);
    chk("t6_s_stb", s_stb, 0);
    chk("t6_m0_ack", m0_ack, 0);
    chk("t6_m0_err", m0_err, 0);
    chk("t6_m0_stall", m0_stall, 1);
    chk("t6_m1_stall", m1_stall, 1);
    step();
    rst = 0; s_ack = 0; m1_cyc = 1;
    step();
    #1 chk("t6_m0_wins", m0_stall, 0);
    chk("t6_m1_stall2", m1_stall, 1);
    clr();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
